// File: rtl/neuron_layer_sched_if.sv
// Bus bundle between neuron_layer_sched (master) and its shared Neuron datapath / host (slave).
// Defining NEURON_SCHED_ARGMAX_EN adds the max_idx/max_val result signals.
interface neuron_layer_sched_if #(
  parameter int NUM_NEURONS = 10
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    err_timeout;
  logic        [IDX_W-1:0] wgt_sel;
  logic                    neu_input_valid;
  logic                    neu_output_valid;
  logic signed [25:0]      neu_out;
  logic                    res_valid;
  logic        [IDX_W-1:0] res_idx;
  logic signed [25:0]      res_data;
`ifdef NEURON_SCHED_ARGMAX_EN
  logic        [IDX_W-1:0] max_idx;
  logic signed [25:0]      max_val;
`endif

  modport master (
    input  start, neu_output_valid, neu_out,
    output busy, done, err_timeout, wgt_sel, neu_input_valid,
`ifdef NEURON_SCHED_ARGMAX_EN
    output max_idx, max_val,
`endif
    output res_valid, res_idx, res_data
  );

  modport slave (
    output start, neu_output_valid, neu_out,
    input  busy, done, err_timeout, wgt_sel, neu_input_valid,
`ifdef NEURON_SCHED_ARGMAX_EN
    input  max_idx, max_val,
`endif
    input  res_valid, res_idx, res_data
  );
endinterface

// File: rtl/neuron_layer_sched.sv
// Layer scheduler: runs NUM_NEURONS evaluations through one shared 64-input Neuron datapath.
// Optional NEURON_SCHED_ARGMAX_EN tracks the index/value of the largest signed result.
module neuron_layer_sched #(
  parameter int NUM_NEURONS = 10,
  parameter int IV_HOLD     = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 GlobalReset,
  neuron_layer_sched_if.master io_bus
);
  localparam int IDX_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_MAX = (IV_HOLD > TIMEOUT_CYC) ? IV_HOLD : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_wgtSel;
  logic [IDX_W-1:0]   r_resIdx;
  logic signed [25:0] r_resData;
  logic               r_ovPrev;
  logic               r_errTimeout;
  logic               w_edge;
  logic               w_timeout;
  logic               w_busy;
  logic               w_done;
  logic               w_inputValid;
  logic               w_resValid;

  // Only a fresh rising edge counts, so a valid level left over from the previous neuron is ignored.
  assign w_edge    = io_bus.neu_output_valid & ~r_ovPrev;
  assign w_timeout = (r_state == S_WAIT) && !w_edge && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_inputValid = 1'b0;
    w_resValid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (io_bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = S_FIRE;
      end
      S_FIRE: begin
        w_inputValid = 1'b1;
        if (r_cnt == IV_LAST) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_edge) begin
          w_next = S_STORE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_STORE: begin
        w_resValid = 1'b1;
        w_next     = (r_wgtSel == LAST_IDX) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // One counter serves both the FIRE hold and the WAIT timeout; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_cnt <= '0;
    end else if ((r_state != w_next) || !((r_state == S_FIRE) || (r_state == S_WAIT))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_ovPrev     <= 1'b0;
      r_wgtSel     <= '0;
      r_resIdx     <= '0;
      r_resData    <= '0;
      r_errTimeout <= 1'b0;
    end else begin
      r_ovPrev <= io_bus.neu_output_valid;
      if ((r_state == S_IDLE) && io_bus.start) begin
        r_wgtSel     <= '0;
        r_errTimeout <= 1'b0;
      end
      if ((r_state == S_WAIT) && w_edge) begin
        r_resIdx  <= r_wgtSel;
        r_resData <= io_bus.neu_out;
      end
      if (w_timeout) begin
        r_errTimeout <= 1'b1;
      end
      if ((r_state == S_STORE) && (r_wgtSel != LAST_IDX)) begin
        r_wgtSel <= r_wgtSel + IDX_W'(1);
      end
    end
  end

`ifdef NEURON_SCHED_ARGMAX_EN
  logic [IDX_W-1:0]   r_maxIdx;
  logic signed [25:0] r_maxVal;

  // Strict greater-than keeps the lower index on ties; neuron 0 always seeds the running max.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_maxIdx <= '0;
      r_maxVal <= '0;
    end else if ((r_state == S_STORE) && ((r_wgtSel == '0) || (r_resData > r_maxVal))) begin
      r_maxIdx <= r_wgtSel;
      r_maxVal <= r_resData;
    end
  end

  assign io_bus.max_idx = r_maxIdx;
  assign io_bus.max_val = r_maxVal;
`endif

  assign io_bus.busy            = w_busy;
  assign io_bus.done            = w_done;
  assign io_bus.neu_input_valid = w_inputValid;
  assign io_bus.res_valid       = w_resValid;
  assign io_bus.err_timeout     = r_errTimeout;
  assign io_bus.wgt_sel         = r_wgtSel;
  assign io_bus.res_idx         = r_resIdx;
  assign io_bus.res_data        = r_resData;
endmodule

// File: tb/tb_neuron_layer_sched.sv
// Bench for neuron_layer_sched: a cycle timeline is planned from the layer rules, then replayed and compared.
// Build with +define+NEURON_SCHED_ARGMAX_EN to also check max_idx/max_val.
module tb_neuron_layer_sched;
  localparam int N    = 3;
  localparam int IV   = 10;
  localparam int TO   = 255;
  localparam int MAXC = 12000;

  logic clk = 1'b0;
  logic GlobalReset;
  always #5 clk = ~clk;

  neuron_layer_sched_if #(.NUM_NEURONS(N)) bus ();
  neuron_layer_sched #(.NUM_NEURONS(N), .IV_HOLD(IV), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .io_bus(bus)
  );

  neuron_layer_sched_if #(.NUM_NEURONS(1)) bus1 ();
  neuron_layer_sched #(.NUM_NEURONS(1), .IV_HOLD(IV), .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .GlobalReset(GlobalReset), .io_bus(bus1)
  );

  // Planned stimulus and expected outputs, indexed by cycle number.
  bit                 stRst   [MAXC];
  bit                 stStart [MAXC];
  bit                 stOv    [MAXC];
  logic signed [25:0] stOut   [MAXC];
  bit exBusy [MAXC];
  bit exDone [MAXC];
  bit exErr  [MAXC];
  bit exIv   [MAXC];
  bit exRv   [MAXC];
  bit exZero [MAXC];
  int exWgt    [MAXC];
  int exIdx    [MAXC];
  int exData   [MAXC];
  int exMaxIdx [MAXC];
  int exMaxVal [MAXC];

  int cur, lim, mWgt, lastDoneCyc, tieDoneCyc, lastCyc;
  bit mErr;
  int dMode [3];
  int dP1   [3];
  int dP2   [3];
  int dVal  [3];

  int nChecks = 0;
  int nErrors = 0;
  int nomN = 0;
  int nomDone = -1;
  int nomCyc [3] = '{-1, -1, -1};
  int nomDat [3] = '{0, 0, 0};
  int litCyc [3] = '{38, 71, 104};
  int litDat [3] = '{100, -50, 300};

  task automatic chk(input string nm, input int c, input logic signed [31:0] act,
                     input logic signed [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nErrors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", nm, c, act, expv);
    end
  endtask

  task automatic putCyc(input int c, input bit b, input bit iv, input bit rv, input bit dn, input int w);
    if (c <= lim) begin
      exBusy[c] = b;
      exIv[c]   = iv;
      exRv[c]   = rv;
      exDone[c] = dn;
      exErr[c]  = mErr;
      exWgt[c]  = w;
    end
  endtask

  task automatic idleTo(input int n);
    for (int c = cur; c < n; c++) putCyc(c, 1'b0, 1'b0, 1'b0, 1'b0, mWgt);
    if (n > cur) cur = n;
  endtask

  // Plans one layer request: start, per-neuron datapath responses, and every expected output.
  task automatic runLayer(input int gap, input int abortOff, input bit busyStarts,
                          input bit useDir, input bit allowTo);
    int s, L, L0, w0, e, mode, d, a, b, h, val, mi, mv, r;
    bit tout;
    idleTo(cur + gap);
    s = cur;
    stStart[s] = 1'b1;
    idleTo(s + 1);
    L = s + 1;
    L0 = L;
    lim = (abortOff >= 0) ? (L + abortOff) : (MAXC - 1);
    mErr = 1'b0;
    mWgt = 0;
    tout = 1'b0;
    mi = 0;
    mv = 0;
    for (int k = 0; k < N && !tout; k++) begin
      if (useDir) begin
        mode = dMode[k]; d = dP1[k]; a = dP1[k]; b = dP2[k]; val = dVal[k]; h = 1;
      end else begin
        r = int'($urandom_range(0, 9));
        mode = (r == 9 && allowTo) ? 2 : ((r >= 6) ? 1 : 0);
        d = int'($urandom_range(0, 25));
        a = int'($urandom_range(1, 4));
        b = int'($urandom_range(1, 6));
        h = int'($urandom_range(1, 2));
        val = int'($urandom_range(0, 67108863)) - 33554432;
      end
      putCyc(L, 1'b1, 1'b0, 1'b0, 1'b0, k);
      for (int j = 1; j <= IV; j++) putCyc(L + j, 1'b1, 1'b1, 1'b0, 1'b0, k);
      w0 = L + 1 + IV;
      if (mode == 2) begin
        for (int j = 0; j < TO; j++) putCyc(w0 + j, 1'b1, 1'b0, 1'b0, 1'b0, k);
        cur = w0 + TO;
        mErr = 1'b1;
        mWgt = k;
        tout = 1'b1;
      end else begin
        if (mode == 1) begin
          for (int c = L; c < w0 + a; c++) if (c <= lim) stOv[c] = 1'b1;
          e = w0 + a + b;
        end else begin
          e = w0 + d;
        end
        for (int c = w0; c <= e; c++) putCyc(c, 1'b1, 1'b0, 1'b0, 1'b0, k);
        for (int j = 0; j < h; j++) if (e + j <= lim) stOv[e + j] = 1'b1;
        if (e <= lim) stOut[e] = 26'(val);
        putCyc(e + 1, 1'b1, 1'b0, 1'b1, 1'b0, k);
        if (e + 1 <= lim) begin
          exIdx[e + 1]  = k;
          exData[e + 1] = val;
        end
        if (k == 0 || val > mv) begin
          mi = k;
          mv = val;
        end
        if (k == N - 1) begin
          putCyc(e + 2, 1'b1, 1'b0, 1'b0, 1'b1, k);
          if (e + 2 <= lim) begin
            exMaxIdx[e + 2] = mi;
            exMaxVal[e + 2] = mv;
            lastDoneCyc = e + 2;
          end
          cur = e + 3;
          mWgt = k;
        end else begin
          L = e + 2;
        end
      end
    end
    if (busyStarts) begin
      for (int c = L0 + 2; c < cur; c += 7) if (c <= lim && exBusy[c]) stStart[c] = 1'b1;
    end
    if (lim < cur) begin
      stRst[lim]   = 1'b1;
      stStart[lim] = 1'b1;
      cur  = lim + 1;
      mErr = 1'b0;
      mWgt = 0;
      exZero[cur] = 1'b1;
    end
    lim = MAXC - 1;
  endtask

  task automatic setDir(input int m0, input int p10, input int p20, input int v0,
                        input int m1, input int p11, input int p21, input int v1,
                        input int m2, input int p12, input int p22, input int v2);
    dMode = '{m0, m1, m2};
    dP1   = '{p10, p11, p12};
    dP2   = '{p20, p21, p22};
    dVal  = '{v0, v1, v2};
  endtask

  task automatic buildScenario();
    int abortOff;
    for (int c = 0; c < MAXC; c++) stOut[c] = 26'($urandom);
    lim = MAXC - 1;
    mErr = 1'b0;
    mWgt = 0;
    cur = 1;
    stRst[0] = 1'b1;
    stRst[1] = 1'b1;
    stStart[1] = 1'b1;
    exZero[1] = 1'b1;
    exZero[2] = 1'b1;
    // Nominal layer, start in cycle 5, valid 20 cycles after input_valid falls.
    setDir(0, 20, 0, 100, 0, 20, 0, -50, 0, 20, 0, 300);
    runLayer(4, -1, 1'b0, 1'b1, 1'b0);
    // Stale valid on neuron 0, immediate edge on neuron 1.
    setDir(1, 3, 5, 1234, 0, 0, 0, -1, 0, 7, 0, 77);
    runLayer(6, -1, 1'b0, 1'b1, 1'b0);
    setDir(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runLayer(3, -1, 1'b0, 1'b1, 1'b0);
    runLayer(4, -1, 1'b0, 1'b0, 1'b0);
    // Reset in the fourth FIRE cycle, then a clean layer.
    runLayer(3, 4, 1'b0, 1'b0, 1'b0);
    runLayer(2, -1, 1'b0, 1'b0, 1'b0);
    runLayer(3, -1, 1'b1, 1'b0, 1'b0);
    runLayer(1, -1, 1'b1, 1'b0, 1'b1);
    setDir(0, 2, 0, -7, 0, 5, 0, -7, 0, 1, 0, -9);
    runLayer(2, -1, 1'b0, 1'b1, 1'b0);
    tieDoneCyc = lastDoneCyc;
    for (int i = 0; i < 20; i++) begin
      if (cur > MAXC - 1200) break;
      abortOff = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 120)) : -1;
      runLayer(int'($urandom_range(0, 5)), abortOff, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    idleTo(cur + 6);
    lastCyc = cur - 1;
  endtask

  task automatic applyStimulus(input int c);
    GlobalReset          = stRst[c];
    bus.start            = stStart[c];
    bus.neu_output_valid = stOv[c];
    bus.neu_out          = stOut[c];
    bus1.start            = (c == 3);
    bus1.neu_output_valid = (c == 17);
    bus1.neu_out          = (c == 17) ? 26'sd42 : 26'(c * 3 + 1);
  endtask

  task automatic checkOutput(input int c);
    chk("busy", c, bus.busy, exBusy[c]);
    chk("done", c, bus.done, exDone[c]);
    chk("err_timeout", c, bus.err_timeout, exErr[c]);
    chk("neu_input_valid", c, bus.neu_input_valid, exIv[c]);
    chk("res_valid", c, bus.res_valid, exRv[c]);
    chk("wgt_sel", c, bus.wgt_sel, exWgt[c]);
    if (exRv[c]) begin
      chk("res_idx", c, bus.res_idx, exIdx[c]);
      chk("res_data", c, $signed(bus.res_data), exData[c]);
    end
    if (exZero[c]) begin
      chk("res_idx_after_reset", c, bus.res_idx, 0);
      chk("res_data_after_reset", c, $signed(bus.res_data), 0);
    end
`ifdef NEURON_SCHED_ARGMAX_EN
    if (exDone[c]) begin
      chk("max_idx", c, bus.max_idx, exMaxIdx[c]);
      chk("max_val", c, $signed(bus.max_val), exMaxVal[c]);
    end
    if (exZero[c]) begin
      chk("max_idx_after_reset", c, bus.max_idx, 0);
      chk("max_val_after_reset", c, $signed(bus.max_val), 0);
    end
    if (c == 105) begin
      chk("nominal_max_idx", c, bus.max_idx, 2);
      chk("nominal_max_val", c, $signed(bus.max_val), 300);
    end
    if (c == tieDoneCyc) begin
      chk("tie_max_idx", c, bus.max_idx, 0);
      chk("tie_max_val", c, $signed(bus.max_val), -7);
    end
`endif
    if (c <= 110) begin
      if (bus.res_valid === 1'b1 && nomN < 3) begin
        nomCyc[nomN] = c;
        nomDat[nomN] = $signed(bus.res_data);
        nomN++;
      end
      if (bus.done === 1'b1 && nomDone < 0) nomDone = c;
    end
    if (c == 17) begin
      chk("n1_busy_in_wait", c, bus1.busy, 1);
      chk("n1_no_early_res_valid", c, bus1.res_valid, 0);
    end
    if (c == 18) begin
      chk("n1_res_valid", c, bus1.res_valid, 1);
      chk("n1_res_idx", c, bus1.res_idx, 0);
      chk("n1_res_data", c, $signed(bus1.res_data), 42);
      chk("n1_done_not_yet", c, bus1.done, 0);
    end
    if (c == 19) begin
      chk("n1_done", c, bus1.done, 1);
      chk("n1_res_valid_gone", c, bus1.res_valid, 0);
    end
    if (c == 20) begin
      chk("n1_idle", c, bus1.busy, 0);
      chk("n1_done_single", c, bus1.done, 0);
    end
  endtask

  initial begin
    buildScenario();
    $display("[TB] planned %0d cycles", lastCyc);
    applyStimulus(0);
    for (int c = 1; c <= lastCyc; c++) begin
      @(posedge clk);
      #1;
      checkOutput(c);
      applyStimulus(c);
    end
    for (int k = 0; k < 3; k++) begin
      chk("nominal_res_cycle", k, nomCyc[k], litCyc[k]);
      chk("nominal_res_data", k, nomDat[k], litDat[k]);
    end
    chk("nominal_done_cycle", 0, nomDone, 105);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/neuron_layer_sched.md
NEURON_LAYER_SCHED -- requirements
Module: neuron_layer_sched

Interface
REQ-001 Parameter NUM_NEURONS, default 10: number of output neurons sequenced through one shared 64-input Neuron datapath.
REQ-002 Parameter IV_HOLD, default 10: cycles neu_input_valid is held high per neuron evaluation.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum WAIT cycles before abort.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 GlobalReset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run a full layer; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when the layer completes without error.
REQ-009 err_timeout  output  1  sticky; set on WAIT timeout, cleared by next accepted start or reset.
REQ-010 wgt_sel  output  clog2(NUM_NEURONS)  index of the weight set the datapath's weight mux/ROM must present.
REQ-011 neu_input_valid  output  1  drives the datapath Input_valid.
REQ-012 neu_output_valid  input  1  datapath Output_valid.
REQ-013 neu_out  input  26  datapath signed accumulated result.
REQ-014 res_valid  output  1  one-cycle pulse per stored neuron result.
REQ-015 res_idx  output  clog2(NUM_NEURONS)  neuron index of the current result.
REQ-016 res_data  output  26  captured neu_out, two's complement.

Function
REQ-017 FSM states: IDLE, LOAD, FIRE, WAIT, STORE, DONE.
REQ-018 IDLE -> LOAD on start; wgt_sel cleared to 0, err_timeout cleared.
REQ-019 LOAD lasts exactly 1 cycle (weight-mux settle), then FIRE.
REQ-020 FIRE: neu_input_valid high for exactly IV_HOLD consecutive cycles, then WAIT.
REQ-021 WAIT: advance to STORE only on a 0->1 transition of neu_output_valid seen after entering WAIT; a level already high on entry is ignored.
REQ-022 WAIT counter increments each cycle; at TIMEOUT_CYC without a valid edge, set err_timeout, deassert all pulses, go IDLE without done.
REQ-023 STORE: 1 cycle; res_valid=1, res_idx=wgt_sel, res_data=neu_out sampled on the edge-detect cycle.
REQ-024 After STORE: if wgt_sel==NUM_NEURONS-1 go DONE, else increment wgt_sel and go LOAD.
REQ-025 DONE: 1 cycle, done=1, then IDLE.
REQ-026 wgt_sel stable from LOAD through STORE of the same neuron; never exceeds NUM_NEURONS-1.
REQ-027 start while busy is ignored; no queuing.
REQ-028 Single-neuron evaluation latency from LOAD entry to res_valid = 1 + IV_HOLD + W + 1 cycles, W = WAIT cycles until edge.
REQ-029 NUM_NEURONS=1: one evaluation, then DONE.

Reset
REQ-030 GlobalReset sampled high: state=IDLE, busy=0, done=0, err_timeout=0, neu_input_valid=0, res_valid=0, wgt_sel=0, res_idx=0, res_data=0, counters=0, edge-detect register=0.
REQ-031 Reset mid-operation (any state) aborts immediately with no done/res_valid pulse on the following cycle.
REQ-032 Reset has priority over start in the same cycle.

Configuration
REQ-033 Macro NEURON_SCHED_ARGMAX_EN: when defined, adds outputs max_idx (clog2(NUM_NEURONS)) and max_val (26), updated in STORE with signed compare, strict greater-than (ties keep lower index), initialised from neuron 0, valid when done pulses, reset to 0.
REQ-034 When NEURON_SCHED_ARGMAX_EN undefined, max_idx/max_val ports and comparison logic are absent; all other behaviour identical.

Verification
REQ-035 Nominal: NUM_NEURONS=3, start at cycle 5, datapath model raises output_valid 20 cycles after input_valid falls, neu_out=100,-50,300 -> res_valid x3 with idx 0,1,2 and data 100,-50,300; done once; with ARGMAX_EN max_idx=2, max_val=300.
REQ-036 Stale valid: neu_output_valid held high entering WAIT, drops 3 cycles later, rises 5 cycles later -> STORE only after that rise; no early res_valid.
REQ-037 Timeout: TIMEOUT_CYC=255, output_valid never rises -> err_timeout=1 exactly 255 cycles into WAIT, busy=0 next cycle, no done; next start clears err_timeout.
REQ-038 Reset mid-FIRE at cycle 4 of IV_HOLD -> neu_input_valid=0 and busy=0 the following cycle; subsequent start runs a full layer from wgt_sel=0.
REQ-039 start pulses during busy (every 7 cycles) -> exactly one done per accepted start; IV_HOLD=10 checked as exactly 10 high cycles per neuron.
REQ-040 ARGMAX tie: neu_out=-7,-7,-9 -> max_idx=0, max_val=-7.
